// File: rtl/letras2notas_pkg.sv
// letras2notas_pkg: shared FSM encoding, blank code and letter-to-note table
package letras2notas_pkg;

    typedef enum logic [1:0] {
        ESPERA_SYNC = 2'd0,
        COLETA      = 2'd1,
        AVALIA      = 2'd2
    } estado_t;

    localparam logic [4:0] BRANCO = 5'b00000;

    // Indexed by letras[2:0]; entry 0 is unused because code 0 is never a note
    localparam logic [2:0] TABELA_NOTAS [8] = '{3'd0, 3'd5, 3'd6, 3'd0, 3'd1, 3'd2, 3'd3, 3'd4};

endpackage

// File: rtl/letras2notas_letra2nota.sv
// letra2nota: combinational decode of the slot-3 letter code into a note
module letra2nota
    import letras2notas_pkg::*;
(
    input  logic [4:0] letras,
    output logic [2:0] nota,
    output logic       codigo_ok
);

    // Only codes 1..7 with the upper two bits clear name a note
    always_comb begin
        nota      = TABELA_NOTAS[letras[2:0]];
        codigo_ok = (letras[4:3] == 2'b00) && (letras[2:0] != 3'd0);
    end

endmodule

// File: rtl/letras2notas.sv
// letras2notas: frames scanned display letters and confirms stable notes
module letras2notas
    import letras2notas_pkg::*;
#(
    parameter int N_CONF = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [4:0] letras,
    input  logic [1:0] contagem_display,
    input  logic       amostra,
    output logic [2:0] nota,
    output logic       nota_valida,
    output logic       erro
);

    localparam logic [2:0] N = 3'(N_CONF);

    estado_t    estado;
    logic [1:0] esperado;
    logic       quadro_ok;
    logic [2:0] candidato;
    logic [2:0] contador;
    logic       primeiro;
    logic [2:0] nota_dec;
    logic       codigo_ok;
    logic       final_ok;
    logic [2:0] contador_novo;
    logic       confirma;

    letra2nota u_letra2nota (
        .letras    (letras),
        .nota      (nota_dec),
        .codigo_ok (codigo_ok)
    );

    // Frame verdict computed on the slot-3 sample so the pulse lands in the AVALIA cycle
    always_comb begin
        final_ok      = quadro_ok && codigo_ok;
        contador_novo = (nota_dec == candidato) ? ((contador >= N) ? N : contador + 3'd1) : 3'd1;
        confirma      = final_ok && (contador_novo == N) && ((nota_dec != nota) || primeiro);
    end

    // Frame sequencing, confirmation counting and registered pulse outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            estado      <= ESPERA_SYNC;
            esperado    <= 2'd1;
            quadro_ok   <= 1'b0;
            candidato   <= 3'd0;
            contador    <= 3'd0;
            primeiro    <= 1'b1;
            nota        <= 3'd0;
            nota_valida <= 1'b0;
            erro        <= 1'b0;
        end else begin
            nota_valida <= 1'b0;
            erro        <= 1'b0;
            case (estado)
                ESPERA_SYNC: begin
                    if (amostra && contagem_display == 2'd0) begin
                        estado    <= COLETA;
                        esperado  <= 2'd1;
                        quadro_ok <= (letras == BRANCO);
                    end
                end
                COLETA: begin
                    if (amostra) begin
                        if (contagem_display != esperado) begin
                            erro <= 1'b1;
                            if (contagem_display == 2'd0) begin
                                esperado  <= 2'd1;
                                quadro_ok <= (letras == BRANCO);
                            end else begin
                                estado <= ESPERA_SYNC;
                            end
                        end else if (contagem_display == 2'd3) begin
                            estado <= AVALIA;
                            if (!final_ok) begin
                                erro     <= 1'b1;
                                contador <= 3'd0;
                            end else begin
                                candidato <= nota_dec;
                                contador  <= contador_novo;
                                if (confirma) begin
                                    nota        <= nota_dec;
                                    nota_valida <= 1'b1;
                                    primeiro    <= 1'b0;
                                end
                            end
                        end else begin
                            esperado  <= esperado + 2'd1;
                            quadro_ok <= quadro_ok && (letras == BRANCO);
                        end
                    end
                end
                default: estado <= ESPERA_SYNC;
            endcase
        end
    end

endmodule

// File: tb/tb_letras2notas.sv
// tb_letras2notas: directed and randomized checks against a frame-level model
module tb_letras2notas;

    localparam int N_CONF = 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       amostra = 1'b0;
    logic [4:0] letras = 5'd0;
    logic [1:0] contagem_display = 2'd0;
    logic [2:0] nota;
    logic       nota_valida;
    logic       erro;

    int checks = 0;
    int errors = 0;

    letras2notas #(.N_CONF(N_CONF)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .letras           (letras),
        .contagem_display (contagem_display),
        .amostra          (amostra),
        .nota             (nota),
        .nota_valida      (nota_valida),
        .erro             (erro)
    );

    always #5 clk = ~clk;

    logic [2:0] m_nota;
    logic       m_primeiro;
    logic       m_busy;
    logic       m_val;
    logic       m_err;
    int         m_len;
    logic [4:0] m_buf [4];
    logic [2:0] m_hist [$];

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_nota = 3'd0;
        m_primeiro = 1'b1;
        m_busy = 1'b0;
        m_len = 0;
        m_val = 1'b0;
        m_err = 1'b0;
        m_hist.delete();
    endtask

    // A complete frame: judge it, then confirm when the last N_CONF valid notes agree
    task automatic model_judge();
        logic good;
        int   n;
        logic same;
        good = m_buf[0] == 5'd0 && m_buf[1] == 5'd0 && m_buf[2] == 5'd0 &&
               m_buf[3][4:3] == 2'b00 && m_buf[3][2:0] != 3'd0;
        if (!good) begin
            m_err = 1'b1;
            m_hist.delete();
        end else begin
            n = (int'(m_buf[3][2:0]) + 4) % 7;
            m_hist.push_back(3'(n));
            if (m_hist.size() > N_CONF) void'(m_hist.pop_front());
            same = (m_hist.size() == N_CONF);
            foreach (m_hist[i]) if (m_hist[i] != 3'(n)) same = 1'b0;
            if (same && (3'(n) != m_nota || m_primeiro)) begin
                m_nota = 3'(n);
                m_val = 1'b1;
                m_primeiro = 1'b0;
            end
        end
    endtask

    task automatic model_step(input logic a, input logic [1:0] idx, input logic [4:0] l);
        m_val = 1'b0;
        m_err = 1'b0;
        if (m_busy) begin
            m_busy = 1'b0;
        end else if (a) begin
            if (m_len == 0) begin
                if (idx == 2'd0) begin
                    m_buf[0] = l;
                    m_len = 1;
                end
            end else if (int'(idx) == m_len) begin
                m_buf[m_len] = l;
                m_len++;
                if (m_len == 4) begin
                    model_judge();
                    m_len = 0;
                    m_busy = 1'b1;
                end
            end else begin
                m_err = 1'b1;
                m_len = 0;
                if (idx == 2'd0) begin
                    m_buf[0] = l;
                    m_len = 1;
                end
            end
        end
    endtask

    task automatic tick(input logic a, input logic [1:0] idx, input logic [4:0] l);
        amostra = a;
        contagem_display = idx;
        letras = l;
        @(posedge clk);
        #1;
        model_step(a, idx, l);
        chk("nota", 8'(nota), 8'(m_nota));
        chk("nota_valida", 8'(nota_valida), 8'(m_val));
        chk("erro", 8'(erro), 8'(m_err));
        chk("exclusive", 8'(nota_valida & erro), 8'd0);
    endtask

    task automatic gap();
        if ($urandom_range(0, 3) == 0) tick(1'b0, 2'($urandom_range(0, 3)), 5'($urandom));
    endtask

    task automatic send_frame(input logic [4:0] l0, input logic [4:0] l1, input logic [4:0] l2, input logic [4:0] l3);
        tick(1'b1, 2'd0, l0);
        gap();
        tick(1'b1, 2'd1, l1);
        gap();
        tick(1'b1, 2'd2, l2);
        gap();
        tick(1'b1, 2'd3, l3);
        tick(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 5'($urandom));
    endtask

    task automatic do_reset();
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("rst_nota", 8'(nota), 8'd0);
        chk("rst_valida", 8'(nota_valida), 8'd0);
        chk("rst_erro", 8'(erro), 8'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        logic [4:0] fr [4];
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("reset_nota", 8'(nota), 8'd0);
        chk("reset_valida", 8'(nota_valida), 8'd0);
        chk("reset_erro", 8'(erro), 8'd0);
        rst_n = 1'b1;
        tick(1'b0, 2'd0, 5'd0);

        send_frame(5'd0, 5'd0, 5'd0, 5'd4);
        send_frame(5'd0, 5'd0, 5'd0, 5'd4);
        chk("two_frames_code4", 8'(nota), 8'd1);

        send_frame(5'd0, 5'd0, 5'd0, 5'd1);
        send_frame(5'd0, 5'd0, 5'd0, 5'd1);
        chk("code1_note5", 8'(nota), 8'd5);
        send_frame(5'd0, 5'd0, 5'd0, 5'd2);
        send_frame(5'd0, 5'd0, 5'd0, 5'd2);
        chk("code2_note6", 8'(nota), 8'd6);

        send_frame(5'd0, 5'b00011, 5'd0, 5'd7);
        send_frame(5'd0, 5'd0, 5'd0, 5'd7);
        chk("after_bad_slot1_one_frame", 8'(nota), 8'd6);
        send_frame(5'd0, 5'd0, 5'd0, 5'd7);
        chk("code7_note4", 8'(nota), 8'd4);

        tick(1'b1, 2'd0, 5'd0);
        tick(1'b1, 2'd1, 5'd0);
        tick(1'b1, 2'd3, 5'd0);
        chk("skip_index_erro", 8'(erro), 8'd1);
        send_frame(5'd0, 5'd0, 5'd0, 5'd5);
        send_frame(5'd0, 5'd0, 5'd0, 5'd5);
        chk("resync_note2", 8'(nota), 8'd2);

        send_frame(5'd0, 5'd0, 5'd0, 5'b01001);
        send_frame(5'd0, 5'd0, 5'd0, 5'b00000);
        chk("bad_slot3_keeps_note", 8'(nota), 8'd2);

        tick(1'b1, 2'd0, 5'd0);
        tick(1'b1, 2'd1, 5'd0);
        tick(1'b1, 2'd2, 5'd0);
        do_reset();
        chk("midframe_reset_note", 8'(nota), 8'd0);
        tick(1'b0, 2'd0, 5'd0);
        tick(1'b1, 2'd3, 5'd4);
        send_frame(5'd0, 5'd0, 5'd0, 5'd4);
        chk("one_frame_no_confirm", 8'(nota), 8'd0);
        send_frame(5'd0, 5'd0, 5'd0, 5'd4);
        chk("post_reset_confirm", 8'(nota), 8'd1);

        do_reset();
        send_frame(5'd0, 5'd0, 5'd0, 5'd3);
        send_frame(5'd0, 5'd0, 5'd0, 5'd3);
        chk("first_confirm_note0", 8'(nota), 8'd0);

        for (int k = 0; k < 400; k++) begin
            int kind;
            kind = $urandom_range(0, 19);
            if (kind < 12) begin
                send_frame(5'd0, 5'd0, 5'd0, 5'($urandom_range(1, 3)));
            end else if (kind < 15) begin
                for (int s = 0; s < 4; s++) fr[s] = (s == 3) ? 5'($urandom_range(1, 7)) : 5'd0;
                fr[$urandom_range(0, 3)] = 5'($urandom);
                send_frame(fr[0], fr[1], fr[2], fr[3]);
            end else if (kind < 18) begin
                tick(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 5'($urandom_range(0, 1) ? 0 : $urandom));
            end else if (kind == 18) begin
                tick(1'b0, 2'($urandom_range(0, 3)), 5'($urandom));
            end else if ($urandom_range(0, 3) == 0) begin
                do_reset();
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/letras2notas.md
LETRAS2NOTAS -- requirements
Module: letras2notas

Interface
REQ-001 Parameter N_CONF, default 2, is the number of consecutive identical valid frames required before a note is confirmed (range 1..7).
REQ-002 clk  input  1  the single system clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 letras  input  5  display letter code for the digit currently scanned.
REQ-005 contagem_display  input  2  index of the digit slot whose code is on letras.
REQ-006 amostra  input  1  strobe; letras/contagem_display are sampled only in cycles where amostra=1.
REQ-007 nota  output  3  last confirmed note.
REQ-008 nota_valida  output  1  one-cycle pulse when nota is updated to a newly confirmed value.
REQ-009 erro  output  1  one-cycle pulse on any frame or code error.

Function
REQ-010 One frame is four samples with contagem_display = 0,1,2,3 in that order.
REQ-011 FSM states: ESPERA_SYNC, COLETA, AVALIA.
REQ-012 ESPERA_SYNC: stays until a sample with contagem_display=0, then goes to COLETA with expected index 1.
REQ-013 COLETA: each sample must carry the expected index (1, then 2, then 3); after index 3 it goes to AVALIA.
REQ-014 Out-of-order index in COLETA: erro pulses the next cycle; an index of 0 restarts the frame in COLETA, any other index goes to ESPERA_SYNC.
REQ-015 Slots 0..2 shall carry letras=5'b00000; any other value marks the frame invalid.
REQ-016 Slot 3 decode, letras[4:3] must be 00: codes 1->5, 2->6, 3->0, 4->1, 5->2, 6->3, 7->4.
REQ-017 Slot-3 code 0, or letras[4:3] != 00, marks the frame invalid.
REQ-018 AVALIA lasts exactly one cycle, then returns to ESPERA_SYNC.
REQ-019 In AVALIA, an invalid frame pulses erro and clears the confirmation counter.
REQ-020 In AVALIA, a valid frame whose decoded note equals the candidate increments the counter, saturating at N_CONF.
REQ-021 In AVALIA, a valid frame whose decoded note differs from the candidate loads the new candidate and sets the counter to 1.
REQ-022 When the counter reaches N_CONF and candidate != nota, nota takes the candidate and nota_valida pulses in the same cycle.
REQ-023 A confirmed note equal to the current nota produces no pulse.
REQ-024 The first confirmation after reset always pulses nota_valida, even when the note is 0.
REQ-025 Latency: nota_valida is asserted in the cycle after the slot-3 sample that completes the confirming frame.
REQ-026 Samples arriving while in AVALIA are ignored.
REQ-027 erro and nota_valida are never asserted in the same cycle.

Reset
REQ-028 While rst_n=0: state=ESPERA_SYNC, nota=0, nota_valida=0, erro=0, candidate=0, counter=0, first-confirmation flag set.
REQ-029 Reset mid-frame discards the partial frame; no pulse is emitted on reset release.

Structure
REQ-030 A shared package holds the FSM state encoding, the blank code 5'b00000, and the letter-to-note table constants.
REQ-031 Slot-3 decoding is a combinational sub-module letra2nota (input letras[4:0], outputs nota[2:0] and codigo_ok).

Verification
REQ-032 Reset, then two frames of 0,0,0,code 4 (N_CONF=2) -> nota_valida pulses once after the 2nd frame, nota=1.
REQ-033 Frames with code 1,1,2,2 -> pulse with nota=5, then pulse with nota=6; no erro.
REQ-034 Frame with slot-1 letras=5'b00011 -> erro pulse, counter cleared; next two good code-7 frames -> nota=4.
REQ-035 Index sequence 0,1,3 -> erro pulse, FSM in ESPERA_SYNC; next clean 0..3 frame is accepted.
REQ-036 Slot-3 letras=5'b01001 or 5'b00000 -> erro pulse, nota unchanged.
REQ-037 rst_n dropped after slot 2, then released -> nota=0, no pulse until two full valid frames follow.
